// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, state
// encoding and the field layout of an assembled instruction.
package fetch_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int INSTR_W    = 2 * DATA_W_DEF;

    // Field positions inside a 16-bit instruction word.
    localparam int OPCODE_MSB  = 15;
    localparam int OPCODE_LSB  = 8;
    localparam int OPERAND_MSB = 7;
    localparam int OPERAND_LSB = 0;

    localparam logic [1:0] FETCH_HI = 2'd0;
    localparam logic [1:0] FETCH_LO = 2'd1;
    localparam logic [1:0] VALID    = 2'd2;

    typedef enum logic [1:0] {
        ST_FETCH_HI = FETCH_HI,
        ST_FETCH_LO = FETCH_LO,
        ST_VALID    = VALID
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads an opcode byte then an operand byte from
// instruction memory, bumps the PC once per accepted byte, and hands the
// assembled 16-bit word to decode over a valid/ready handshake.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// FETCH_HI | requesting opcode byte (unless halted)
// FETCH_LO | requesting operand byte; halt ignored so the word completes
// VALID    | instr_out holds a complete instruction, waiting for decode
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     pc_value,
    output logic                  pc_inc,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_req,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    input  logic                  flush,
    input  logic                  halt,
    output logic [2*DATA_W-1:0]   instr_out,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  fetch_busy
);

    fetch_state_e              state_q, state_d;
    logic [DATA_W-1:0]         opcode_q, opcode_d;
    logic [2*DATA_W-1:0]       instr_q, instr_d;
    logic                      req_raw;
    logic                      accept;

    // The memory address simply tracks the PC; wrap-around comes for free.
    assign mem_addr = pc_value;

    // Raw request level per state, before the reset override.
    always_comb begin
        req_raw = 1'b0;
        unique case (state_q)
            ST_FETCH_HI: req_raw = !halt;
            ST_FETCH_LO: req_raw = 1'b1;
            ST_VALID:    req_raw = 1'b0;
            default:     req_raw = 1'b0;
        endcase
    end

    assign mem_req     = req_raw && !reset;
    assign accept      = mem_req && mem_ready;
    // A flush cycle must not bump the PC or it would corrupt the jump load.
    assign pc_inc      = accept && !flush;
    assign fetch_busy  = mem_req && (state_q == ST_FETCH_HI || state_q == ST_FETCH_LO);
    assign instr_valid = (state_q == ST_VALID) && !reset;
    assign instr_out   = instr_q;

    // Next-state, opcode latch and instruction register update.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        instr_d  = instr_q;
        unique case (state_q)
            ST_FETCH_HI: begin
                if (accept) begin
                    opcode_d = mem_rdata;
                    state_d  = ST_FETCH_LO;
                end
            end
            ST_FETCH_LO: begin
                if (accept) begin
                    instr_d = {opcode_q, mem_rdata};
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (instr_ready) begin
                    state_d = ST_FETCH_HI;
                end
            end
            default: state_d = ST_FETCH_HI;
        endcase
        // A taken jump discards any partial word and any byte accepted now.
        if (flush) begin
            state_d  = ST_FETCH_HI;
            opcode_d = '0;
            instr_d  = instr_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH_HI;
            opcode_q <= '0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            instr_q  <= instr_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: models the PC register and a byte
// memory around the fetch unit and checks outputs mid-cycle.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pc_q;
    logic        pc_inc;
    logic [7:0]  mem_addr;
    logic        mem_req;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        flush;
    logic        halt;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_busy;
    logic        pc_load;
    logic [7:0]  pc_load_val;

    logic [7:0]  mem [256];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    // PC register: control load wins, otherwise increment from fetch.
    always @(posedge clk) begin
        if (reset)        pc_q <= 8'h00;
        else if (pc_load) pc_q <= pc_load_val;
        else if (pc_inc)  pc_q <= pc_q + 8'h01;
    end

    assign mem_rdata = mem[mem_addr];

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc_value    (pc_q),
        .pc_inc      (pc_inc),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .flush       (flush),
        .halt        (halt),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_busy  (fetch_busy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'hA1; mem[8'h01] = 8'h5C; mem[8'h02] = 8'h77;
        mem[8'h03] = 8'h88; mem[8'h04] = 8'h99; mem[8'h40] = 8'hC3;
        mem[8'h41] = 8'h3C; mem[8'hFF] = 8'h12;

        reset = 1'b1; mem_ready = 1'b1; instr_ready = 1'b1;
        flush = 1'b0; halt = 1'b0; pc_load = 1'b0; pc_load_val = 8'h00;

        // Reset: outputs forced low even with mem_ready high.
        @(negedge clk); @(negedge clk); #1;
        check("rst_mem_req", 16'(mem_req), 16'h0);
        check("rst_pc_inc", 16'(pc_inc), 16'h0);
        check("rst_busy", 16'(fetch_busy), 16'h0);
        check("rst_valid", 16'(instr_valid), 16'h0);
        check("rst_instr", instr_out, 16'h0000);

        // Basic fetch of 0xA15C.
        @(negedge clk); reset = 1'b0; #1;
        check("c0_pc_inc", 16'(pc_inc), 16'h1);
        check("c0_mem_req", 16'(mem_req), 16'h1);
        check("c0_addr", 16'(mem_addr), 16'h00);
        check("c0_busy", 16'(fetch_busy), 16'h1);
        @(negedge clk); #1;
        check("c1_pc_inc", 16'(pc_inc), 16'h1);
        check("c1_addr", 16'(mem_addr), 16'h01);
        @(negedge clk); #1;
        check("c2_valid", 16'(instr_valid), 16'h1);
        check("c2_instr", instr_out, 16'hA15C);
        check("c2_mem_req", 16'(mem_req), 16'h0);
        check("c2_pc_inc", 16'(pc_inc), 16'h0);
        @(negedge clk); #1;
        check("c3_mem_req", 16'(mem_req), 16'h1);
        check("c3_addr", 16'(mem_addr), 16'h02);
        check("c3_valid", 16'(instr_valid), 16'h0);

        // Memory stall during FETCH_LO.
        @(negedge clk); mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_req", 16'(mem_req), 16'h1);
            check("stall_addr", 16'(mem_addr), 16'h03);
            check("stall_pc_inc", 16'(pc_inc), 16'h0);
            @(negedge clk);
        end
        mem_ready = 1'b1; #1;
        check("stall_done_inc", 16'(pc_inc), 16'h1);

        // Decode back-pressure in VALID.
        @(negedge clk); instr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_valid", 16'(instr_valid), 16'h1);
            check("bp_instr", instr_out, 16'h7788);
            check("bp_mem_req", 16'(mem_req), 16'h0);
            check("bp_pc", 16'(pc_q), 16'h04);
            @(negedge clk);
        end
        instr_ready = 1'b1; #1;
        check("bp_release_valid", 16'(instr_valid), 16'h1);
        @(negedge clk); #1;
        check("bp_hi_req", 16'(mem_req), 16'h1);
        check("bp_hi_valid", 16'(instr_valid), 16'h0);
        check("bp_hi_addr", 16'(mem_addr), 16'h04);

        // Flush in the FETCH_LO accept cycle, jump to 0x40.
        @(negedge clk); flush = 1'b1; pc_load = 1'b1; pc_load_val = 8'h40; #1;
        check("fl_pc_inc", 16'(pc_inc), 16'h0);
        @(negedge clk); flush = 1'b0; pc_load = 1'b0; #1;
        check("fl_valid", 16'(instr_valid), 16'h0);
        check("fl_addr", 16'(mem_addr), 16'h40);
        check("fl_pc_inc_hi", 16'(pc_inc), 16'h1);
        @(negedge clk); #1;
        check("fl_lo_addr", 16'(mem_addr), 16'h41);
        @(negedge clk); #1;
        check("fl_instr", instr_out, 16'hC33C);
        check("fl_instr_valid", 16'(instr_valid), 16'h1);

        // Flush while VALID, jump to 0xFF to exercise PC wrap.
        mem[8'h00] = 8'h34;
        flush = 1'b1; pc_load = 1'b1; pc_load_val = 8'hFF;
        @(negedge clk); flush = 1'b0; pc_load = 1'b0; #1;
        check("wr_valid", 16'(instr_valid), 16'h0);
        check("wr_addr_hi", 16'(mem_addr), 16'hFF);
        check("wr_pc_inc", 16'(pc_inc), 16'h1);
        @(negedge clk); #1;
        check("wr_addr_lo", 16'(mem_addr), 16'h00);
        @(negedge clk); #1;
        check("wr_instr", instr_out, 16'h1234);
        check("wr_pc", 16'(pc_q), 16'h01);

        // Halt in FETCH_HI.
        @(negedge clk); halt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("halt_req", 16'(mem_req), 16'h0);
            check("halt_busy", 16'(fetch_busy), 16'h0);
            check("halt_pc_inc", 16'(pc_inc), 16'h0);
            check("halt_pc", 16'(pc_q), 16'h01);
            @(negedge clk);
        end
        halt = 1'b0; #1;
        check("resume_req", 16'(mem_req), 16'h1);
        check("resume_addr", 16'(mem_addr), 16'h01);

        // Halt rising in FETCH_LO: word completes, then fetch stops.
        @(negedge clk); halt = 1'b1; #1;
        check("halt_lo_req", 16'(mem_req), 16'h1);
        check("halt_lo_inc", 16'(pc_inc), 16'h1);
        check("halt_lo_addr", 16'(mem_addr), 16'h02);
        @(negedge clk); #1;
        check("halt_lo_instr", instr_out, 16'h5C77);
        check("halt_lo_pc", 16'(pc_q), 16'h03);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("halt_stop_req", 16'(mem_req), 16'h0);
            check("halt_stop_valid", 16'(instr_valid), 16'h0);
            @(negedge clk);
        end

        // Reset in the middle of a fetch.
        halt = 1'b0; #1;
        check("pre_rst_req", 16'(mem_req), 16'h1);
        @(negedge clk); reset = 1'b1; #1;
        check("midrst_pc_inc", 16'(pc_inc), 16'h0);
        check("midrst_req", 16'(mem_req), 16'h0);
        @(negedge clk); reset = 1'b0; #1;
        check("post_rst_valid", 16'(instr_valid), 16'h0);
        check("post_rst_instr", instr_out, 16'h0000);
        check("post_rst_addr", 16'(mem_addr), 16'h00);
        check("post_rst_req", 16'(mem_req), 16'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
